// File: rtl/pipeline_hazard_control.sv
// Pipeline hazard controller: tracks the EX/MEM/WB shadow slots and produces
// load-use stalls, branch flushes, multi-cycle EX holds and forwarding selects.
module pipeline_hazard_control #(
  parameter int unsigned REG_ID_WIDTH = 5,
  parameter int unsigned MC_LATENCY   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    id_valid,
  input  logic [REG_ID_WIDTH-1:0] id_rs1,
  input  logic [REG_ID_WIDTH-1:0] id_rs2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [REG_ID_WIDTH-1:0] id_rd,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  input  logic                    id_multi_cycle,
  input  logic                    ex_branch_taken,
  output logic                    stall_fetch,
  output logic                    stall_decode,
  output logic                    flush_if_id,
  output logic                    bubble_id_ex,
  output logic [1:0]              fwd_rs1_sel,
  output logic [1:0]              fwd_rs2_sel,
  output logic                    ex_busy
);

  localparam int unsigned CNT_W = $clog2(MC_LATENCY) + 1;
  localparam logic [1:0]  SEL_RF  = 2'b00;
  localparam logic [1:0]  SEL_MEM = 2'b01;
  localparam logic [1:0]  SEL_WB  = 2'b10;

  // EX slot
  logic                    ex_valid_q, ex_valid_d;
  logic [REG_ID_WIDTH-1:0] ex_rd_q, ex_rd_d;
  logic                    ex_rw_q, ex_rw_d;
  logic                    ex_mr_q, ex_mr_d;
  logic [REG_ID_WIDTH-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_ID_WIDTH-1:0] ex_rs2_q, ex_rs2_d;
  logic                    ex_rs1_used_q, ex_rs1_used_d;
  logic                    ex_rs2_used_q, ex_rs2_used_d;
  logic                    ex_mc_q, ex_mc_d;
  // MEM slot
  logic                    mem_valid_q, mem_valid_d;
  logic [REG_ID_WIDTH-1:0] mem_rd_q, mem_rd_d;
  logic                    mem_rw_q, mem_rw_d;
  logic                    mem_mr_q, mem_mr_d;
  // WB slot
  logic                    wb_valid_q, wb_valid_d;
  logic [REG_ID_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic                    wb_rw_q, wb_rw_d;
  logic                    wb_mr_q, wb_mr_d;
  // multi-cycle countdown
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic busy, branch, load_use, bubble;

  // Hazard decisions; a taken branch overrides load-use, a busy EX ignores both
  always_comb begin
    busy     = (cnt_q != '0);
    branch   = ex_branch_taken && !busy;
    load_use = ex_valid_q && ex_mr_q && (ex_rd_q != '0) && id_valid &&
               ((id_rs1_used && (id_rs1 == ex_rd_q)) ||
                (id_rs2_used && (id_rs2 == ex_rd_q)));
    bubble   = !busy && (branch || load_use);
  end

  // Slot advance and counter next-state
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rd_d       = ex_rd_q;
    ex_rw_d       = ex_rw_q;
    ex_mr_d       = ex_mr_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rs1_used_d = ex_rs1_used_q;
    ex_rs2_used_d = ex_rs2_used_q;
    ex_mc_d       = ex_mc_q;
    mem_valid_d   = ex_valid_q;
    mem_rd_d      = ex_rd_q;
    mem_rw_d      = ex_rw_q;
    mem_mr_d      = ex_mr_q;
    wb_valid_d    = mem_valid_q;
    wb_rd_d       = mem_rd_q;
    wb_rw_d       = mem_rw_q;
    wb_mr_d       = mem_mr_q;
    cnt_d         = cnt_q;
    if (busy) begin
      mem_valid_d = 1'b0;
      cnt_d       = cnt_q - CNT_W'(1);
    end else begin
      ex_valid_d    = id_valid && !bubble;
      ex_rd_d       = id_rd;
      ex_rw_d       = id_reg_write;
      ex_mr_d       = id_mem_read;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rs1_used_d = id_rs1_used;
      ex_rs2_used_d = id_rs2_used;
      ex_mc_d       = id_multi_cycle;
      if (id_valid && !bubble && id_multi_cycle) begin
        cnt_d = CNT_W'(MC_LATENCY - 1);
      end
    end
  end

  // Slot and counter registers; only valid bits and counter need reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q    <= 1'b0;
      ex_rd_q       <= '0;
      ex_rw_q       <= 1'b0;
      ex_mr_q       <= 1'b0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rs1_used_q <= 1'b0;
      ex_rs2_used_q <= 1'b0;
      ex_mc_q       <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_rd_q      <= '0;
      mem_rw_q      <= 1'b0;
      mem_mr_q      <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_rw_q       <= 1'b0;
      wb_mr_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rd_q       <= ex_rd_d;
      ex_rw_q       <= ex_rw_d;
      ex_mr_q       <= ex_mr_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rs1_used_q <= ex_rs1_used_d;
      ex_rs2_used_q <= ex_rs2_used_d;
      ex_mc_q       <= ex_mc_d;
      mem_valid_q   <= mem_valid_d;
      mem_rd_q      <= mem_rd_d;
      mem_rw_q      <= mem_rw_d;
      mem_mr_q      <= mem_mr_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_rw_q       <= wb_rw_d;
      wb_mr_q       <= wb_mr_d;
      cnt_q         <= cnt_d;
    end
  end

  logic [1:0] sel1, sel2;
  logic       mem_fwd_ok, wb_fwd_ok;

  // Forwarding selects for the EX operands; MEM beats WB, register 0 never forwards
  always_comb begin
    mem_fwd_ok = mem_valid_q && mem_rw_q && (mem_rd_q != '0);
    wb_fwd_ok  = wb_valid_q && wb_rw_q && (wb_rd_q != '0);
    sel1 = SEL_RF;
    sel2 = SEL_RF;
    if (ex_valid_q && ex_rs1_used_q) begin
      if (mem_fwd_ok && (mem_rd_q == ex_rs1_q))     sel1 = SEL_MEM;
      else if (wb_fwd_ok && (wb_rd_q == ex_rs1_q))  sel1 = SEL_WB;
    end
    if (ex_valid_q && ex_rs2_used_q) begin
      if (mem_fwd_ok && (mem_rd_q == ex_rs2_q))     sel2 = SEL_MEM;
      else if (wb_fwd_ok && (wb_rd_q == ex_rs2_q))  sel2 = SEL_WB;
    end
  end

  // Outputs forced low while reset is held, including the input-driven flush path
  assign stall_fetch  = reset_n && (busy || (load_use && !branch));
  assign stall_decode = reset_n && (busy || (load_use && !branch));
  assign flush_if_id  = reset_n && branch;
  assign bubble_id_ex = reset_n && bubble;
  assign fwd_rs1_sel  = reset_n ? sel1 : SEL_RF;
  assign fwd_rs2_sel  = reset_n ? sel2 : SEL_RF;
  assign ex_busy      = reset_n && busy;

  logic unused_ok;
  assign unused_ok = ^{ex_mc_q, wb_mr_q};

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Directed bench for pipeline_hazard_control: expected output vectors are
// {stall_fetch, stall_decode, flush_if_id, bubble_id_ex, fwd_rs1_sel, fwd_rs2_sel, ex_busy}.
module tb_pipeline_hazard_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_rs1_used, id_rs2_used;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, id_multi_cycle, ex_branch_taken;
  logic       stall_fetch, stall_decode, flush_if_id, bubble_id_ex, ex_busy;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic       sf1, sd1, fl1, bb1, busy1;
  logic [1:0] f1_1, f2_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_control #(.REG_ID_WIDTH(5), .MC_LATENCY(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_multi_cycle(id_multi_cycle), .ex_branch_taken(ex_branch_taken),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .flush_if_id(flush_if_id),
    .bubble_id_ex(bubble_id_ex), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .ex_busy(ex_busy)
  );

  pipeline_hazard_control #(.REG_ID_WIDTH(5), .MC_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_multi_cycle(id_multi_cycle), .ex_branch_taken(ex_branch_taken),
    .stall_fetch(sf1), .stall_decode(sd1), .flush_if_id(fl1),
    .bubble_id_ex(bb1), .fwd_rs1_sel(f1_1), .fwd_rs2_sel(f2_1),
    .ex_busy(busy1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mc);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_multi_cycle = mc;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    ex_branch_taken = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    #2;
    obs = {stall_fetch, stall_decode, flush_if_id, bubble_id_ex, fwd_rs1_sel, fwd_rs2_sel, ex_busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    ex_branch_taken = 1'b1;
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    chk("reset_outputs", 9'b0000_00_00_0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    drain();
    chk("post_reset_idle", 9'b0000_00_00_0);

    // load-use: load x5 then add reading x5
    set_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("lu_load_in_id", 9'b0000_00_00_0);
    cyc();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", 9'b1101_00_00_0);
    cyc();
    chk("lu_one_cycle", 9'b0000_00_00_0);
    cyc();
    idle();
    chk("lu_fwd_wb", 9'b0000_10_00_0);

    // back-to-back ALU
    drain();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    cyc();
    set_id(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("b2b_no_stall", 9'b0000_00_00_0);
    cyc();
    idle();
    chk("b2b_fwd_mem", 9'b0000_00_01_0);
    cyc();
    chk("b2b_ex_empty", 9'b0000_00_00_0);

    // one-instruction gap
    drain();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    cyc();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    cyc();
    set_id(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("gap_no_fwd", 9'b0000_00_00_0);
    cyc();
    idle();
    chk("gap_fwd_wb", 9'b0000_00_10_0);

    // MEM has priority over WB for the same register
    drain();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    cyc();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    cyc();
    set_id(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    cyc();
    idle();
    chk("prio_mem_over_wb", 9'b0000_00_01_0);

    // multi-cycle mul rd=x8 reading x8, dependent add waiting in decode
    drain();
    set_id(1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    chk("mc_in_id", 9'b0000_00_00_0);
    cyc();
    set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("mc_busy1", 9'b1100_00_00_1);
    checks++;
    assert ({sf1, busy1} === 2'b00) else begin
      errors++;
      $error("FAIL mc_lat1_never_busy: observed %b expected %b", {sf1, busy1}, 2'b00);
    end
    cyc();
    ex_branch_taken = 1'b1;
    chk("mc_busy2_branch_ignored", 9'b1100_00_00_1);
    cyc();
    ex_branch_taken = 1'b0;
    chk("mc_busy3", 9'b1100_00_00_1);
    cyc();
    chk("mc_last_cycle", 9'b0000_00_00_0);
    cyc();
    idle();
    chk("mc_advanced", 9'b0000_01_00_0);

    // branch and load-use in the same cycle
    drain();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    chk("br_over_lu", 9'b0011_00_00_0);
    cyc();
    ex_branch_taken = 1'b0;
    idle();
    chk("br_discarded", 9'b0000_00_00_0);

    // register 0 never stalls or forwards
    drain();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("r0_no_stall", 9'b0000_00_00_0);
    cyc();
    idle();
    chk("r0_no_fwd", 9'b0000_00_00_0);

    // reset during cycle 2 of a multi-cycle op
    drain();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    cyc();
    idle();
    cyc();
    chk("rst_mc_busy", 9'b1100_00_00_1);
    reset_n = 1'b0;
    ex_branch_taken = 1'b1;
    chk("rst_mc_cleared", 9'b0000_00_00_0);
    reset_n = 1'b1;
    ex_branch_taken = 1'b0;
    cyc();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("rst_fresh_no_stall", 9'b0000_00_00_0);
    cyc();
    set_id(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("rst_fresh_flow", 9'b0000_00_00_0);
    cyc();
    idle();
    chk("rst_fresh_fwd", 9'b0000_00_01_0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_control.md
PIPELINE_HAZARD_CONTROL -- requirements
Module: pipeline_hazard_control

Interface
REQ-001 SHALL provide parameter REG_ID_WIDTH, default 5: width of register identifiers.
REQ-002 SHALL provide parameter MC_LATENCY, default 4, legal range 1..16: total EX-stage cycles for a multi-cycle operation.
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports named clk and reset_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 id_valid  in  1  decode stage holds a real instruction.
REQ-007 id_rs1, id_rs2  in  REG_ID_WIDTH  source register ids of the decode instruction.
REQ-008 id_rs1_used, id_rs2_used  in  1  the corresponding source is read.
REQ-009 id_rd  in  REG_ID_WIDTH  destination id; id_reg_write, id_mem_read, id_multi_cycle  in  1  control flags of the decode instruction.
REQ-010 ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-011 stall_fetch, stall_decode  out  1  hold PC and IF/ID register.
REQ-012 flush_if_id  out  1  replace the IF/ID contents with a bubble at the next edge.
REQ-013 bubble_id_ex  out  1  load a bubble into ID/EX at the next edge.
REQ-014 fwd_rs1_sel, fwd_rs2_sel  out  2  EX operand source: 00 register file, 01 EX/MEM, 10 MEM/WB.
REQ-015 ex_busy  out  1  EX is executing a multi-cycle operation and holds its contents.

Function
REQ-016 SHALL keep shadow slots EX, MEM and WB, each holding valid, rd, reg_write and mem_read; the EX slot also holds rs1, rs2, rs1_used, rs2_used and multi_cycle.
REQ-017 SHALL advance the slots each edge while ex_busy=0: EX<=decode fields if id_valid and no bubble, else invalid; MEM<=EX; WB<=MEM.
REQ-018 SHALL, while ex_busy=1, hold EX, load an invalid slot into MEM, and set WB<=MEM.
REQ-019 SHALL detect load-use combinationally: EX.valid, EX.mem_read and EX.rd!=0, together with id_valid and (rs1_used and id_rs1==EX.rd, or rs2_used and id_rs2==EX.rd).
REQ-020 SHALL, on load-use, assert stall_fetch, stall_decode and bubble_id_ex for exactly one cycle per hazard.
REQ-021 SHALL implement a multi-cycle counter, width clog2(MC_LATENCY)+1.
 - Load MC_LATENCY-1 when a valid multi_cycle instruction enters EX.
 - Decrement while nonzero.
 - ex_busy = (counter!=0).
REQ-022 SHALL, while ex_busy=1, assert stall_fetch and stall_decode; bubble_id_ex SHALL be 0 because ID/EX holds.
REQ-023 SHALL, for MC_LATENCY=1, never assert ex_busy.
REQ-024 SHALL sample ex_branch_taken only when ex_busy=0; otherwise it is ignored.
REQ-025 SHALL, on a sampled taken branch, assert flush_if_id and bubble_id_ex in that cycle and deassert stall_fetch and stall_decode.
 - Branch flush takes priority over load-use.
 - The decode instruction is discarded and does not enter the EX slot.
REQ-026 SHALL compute fwd_rsN_sel combinationally from the EX slot:
 - 01 if EX.valid, rsN_used, MEM.valid, MEM.reg_write, MEM.rd!=0 and MEM.rd==EX.rsN;
 - otherwise 10 on the same match against WB;
 - otherwise 00.
 - MEM has priority over WB.
REQ-027 SHALL drive fwd selects to 00 when EX.valid=0.
REQ-028 SHALL never forward register 0 and never flag load-use on register 0.
REQ-029 SHALL treat a write-back to the same register in the same cycle as a decode read as the decode stage's concern; this block SHALL NOT stall for it.

Reset
REQ-030 SHALL, on reset_n=0, asynchronously clear all slot valid bits and the counter.
REQ-031 SHALL drive every output to 0 while reset_n=0.
REQ-032 SHALL, on reset deassertion, treat the pipeline as empty; no stall, flush or forward until instructions arrive.
REQ-033 SHALL, when reset is asserted mid multi-cycle operation, clear ex_busy immediately; the aborted operation leaves no residue.

Verification
REQ-034 Load-use: EX holds load rd=5; ID add rs1=5 -> stall_fetch=stall_decode=bubble_id_ex=1 for one cycle; two cycles later fwd_rs1_sel=10.
REQ-035 Back-to-back ALU: add rd=3, then sub rs2=3 -> no stall; fwd_rs2_sel=01 when sub is in EX. With a gap of one instruction -> 10.
REQ-036 Multi-cycle, MC_LATENCY=4: mul enters EX -> ex_busy=1 for 3 cycles, stalls high, MEM slot invalid during those cycles; mul advances on the 4th edge.
REQ-037 Branch versus load-use in the same cycle -> flush_if_id=1, bubble_id_ex=1, stall_fetch=0; decode instruction never appears in the EX slot.
REQ-038 Register 0: load rd=0, then consumer rs1=0 -> no stall, fwd_rs1_sel=00.
REQ-039 Reset asserted during cycle 2 of a multi-cycle op -> ex_busy=0 and all outputs 0 within the same cycle; after release, a fresh instruction flows with no stall.
